// File: rtl/bram_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// bram_stream_reader_pkg
//   Shared definitions for the BRAM stream reader and for every site that
//   instantiates the external RAM it talks to.
//   - state_t    : reader FSM encoding (also exposed on the debug port)
//   - SUM_W      : width used for in-flight + FIFO occupancy arithmetic
//   - rd_lat_of(): RAM read latency implied by the RAM's OUTPUT_REGISTER
//                  setting ("true" -> 2 cycles, anything else -> 1 cycle).
//                  RAM wrappers call the same function so the two sides
//                  can never disagree on latency.
// -----------------------------------------------------------------------------
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Wide enough for in_flight (<= 2) + FIFO count (<= 3).
  localparam int SUM_W = 4;

  function automatic int rd_lat_of(input string output_register);
    return (output_register == "true") ? 2 : 1;
  endfunction

endpackage

// File: rtl/stream_fwft_fifo.sv
// -----------------------------------------------------------------------------
// stream_fwft_fifo
//   Small first-word-fall-through FIFO. The head word is presented on
//   o_rd_data while o_valid is high; i_rd_en pops it.
//   When the FIFO is empty, a word being written is presented in the same
//   cycle (bypass), so a read result reaches the stream without an extra
//   register stage. If that bypassed word is also popped in the same cycle
//   it is never stored.
// Ports
//   clk, rst   : clock, synchronous active-high reset (clears storage)
//   i_wr_en    : write i_wr_data this cycle (caller guarantees not full)
//   i_wr_data  : write data
//   i_rd_en    : pop the head word (only meaningful while o_valid)
//   o_rd_data  : head word
//   o_valid    : a head word is available
//   o_count    : number of stored words
// -----------------------------------------------------------------------------
module stream_fwft_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_valid,
  output logic [CW-1:0]         o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_empty;
  logic w_bypass;
  logic w_store;
  logic w_take;

  assign w_empty  = (r_count == '0);
  // Word written into an empty FIFO and popped in the same cycle.
  assign w_bypass = w_empty && i_wr_en && i_rd_en;
  assign w_store  = i_wr_en && !w_bypass;
  assign w_take   = i_rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_take) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_store, w_take})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid   = !w_empty || i_wr_en;
  assign o_rd_data = (w_empty && i_wr_en) ? i_wr_data : r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
//   Reads a burst of `length` consecutive words (wrapping at DEPTH-1) from an
//   external single-port RAM and streams them out in address order.
//
//   Stream handshake: a beat transfers on a rising edge where o_valid and
//   o_ready are both high. Once o_valid rises, o_data stays stable and
//   o_valid stays high until the beat transfers; o_valid never depends on
//   o_ready.
//
//   Reads are only issued while in_flight + fifo_count < RD_LAT+1, so every
//   word returning from the RAM has a guaranteed FIFO slot no matter how long
//   the downstream stalls.
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   start        : burst request, sampled only in IDLE
//   base_addr    : first RAM address (sampled with start)
//   length       : words in the burst, 0..DEPTH (sampled with start)
//   busy         : burst in progress
//   done         : one-cycle pulse after the last beat transfers
//                  (or one cycle after a zero-length start)
//   ram_rd_addr  : RAM read address (holds while ram_rd_en is low)
//   ram_rd_en    : RAM read enable
//   ram_rd_data  : RAM read data, valid RD_LAT cycles after ram_rd_en
//   o_data       : stream beat
//   o_valid      : o_data valid
//   o_ready      : downstream ready
//   o_dbg_state  : current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int    DATA_WIDTH      = 8,
  parameter int    DEPTH           = 2,
  parameter string OUTPUT_REGISTER = "false",
  localparam int   AW              = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         ram_rd_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [1:0]            o_dbg_state
);

  localparam int RD_LAT     = rd_lat_of(OUTPUT_REGISTER);
  localparam int FIFO_DEPTH = RD_LAT + 1;
  localparam int FCW        = $clog2(FIFO_DEPTH + 1);
  localparam int LW         = AW + 1;
  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [SUM_W-1:0] CREDIT    = SUM_W'(RD_LAT + 1);

  state_t           r_state;
  logic [AW-1:0]    r_issue_addr;
  logic [AW-1:0]    r_hold_addr;
  logic [LW-1:0]    r_issue_left;
  logic [LW-1:0]    r_beats_left;
  logic             r_busy;
  logic             r_done;
  logic [RD_LAT-1:0] r_tag;

  logic                  w_rd_en;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_valid;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic [FCW-1:0]        w_fifo_count;
  logic [SUM_W-1:0]      w_in_flight;
  logic [SUM_W-1:0]      w_outstanding;
  logic [AW-1:0]         w_next_addr;

  // Reads issued but not yet written into the FIFO.
  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_in_flight = w_in_flight + SUM_W'(r_tag[i]);
    end
  end

  assign w_outstanding = w_in_flight + SUM_W'(w_fifo_count);
  // Gated by rst so nothing is issued or captured while reset is held.
  assign w_rd_en     = !rst && (r_state == ST_ISSUE) && (w_outstanding < CREDIT);
  assign w_push      = !rst && r_tag[RD_LAT-1];
  assign w_pop       = w_fifo_valid && o_ready;
  assign w_next_addr = (r_issue_addr == LAST_ADDR) ? '0 : r_issue_addr + AW'(1);

  // Tag pipeline: the bit leaving the top marks the cycle ram_rd_data holds
  // a word we asked for. Clearing it on reset drops any read still in the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= '0;
    end else begin
      r_tag <= (r_tag << 1) | RD_LAT'(w_rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_issue_addr <= '0;
      r_hold_addr  <= '0;
      r_issue_left <= '0;
      r_beats_left <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_rd_en) begin
        r_hold_addr  <= r_issue_addr;
        r_issue_addr <= w_next_addr;
        r_issue_left <= r_issue_left - LW'(1);
      end

      if (w_pop && (r_state != ST_IDLE)) begin
        r_beats_left <= r_beats_left - LW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (length == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state      <= ST_ISSUE;
              r_issue_addr <= base_addr;
              r_issue_left <= length;
              r_beats_left <= length;
              r_busy       <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // The last beat can never transfer while still issuing, since its
          // read is the one that moves us to DRAIN.
          if (w_rd_en && (r_issue_left == LW'(1))) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && (r_beats_left == LW'(1))) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  stream_fwft_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data (ram_rd_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_valid   (w_fifo_valid),
    .o_count   (w_fifo_count)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign ram_rd_en   = w_rd_en;
  assign ram_rd_addr = w_rd_en ? r_issue_addr : r_hold_addr;
  assign o_data      = w_fifo_data;
  assign o_valid     = w_fifo_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
//   Two readers over 8-word RAM models: u_dut1 with a 1-cycle RAM, u_dut2 with
//   a 2-cycle (output-registered) RAM. RAM[i] = i in both models.
//   Period k is the interval after the k-th rising edge following the cycle
//   in which start is driven (start driven in period 0).
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] base_addr = '0;
  logic [3:0] length = '0;

  logic       start1 = 1'b0, ready1 = 1'b0;
  logic       busy1, done1, ram_rd_en1, o_valid1;
  logic [2:0] ram_rd_addr1;
  logic [7:0] ram_rd_data1 = '0, o_data1;
  logic [1:0] dbg1;

  logic       start2 = 1'b0, ready2 = 1'b0;
  logic       busy2, done2, ram_rd_en2, o_valid2;
  logic [2:0] ram_rd_addr2;
  logic [7:0] ram_rd_data2 = '0, ram_d1_2 = '0, o_data2;
  logic [1:0] dbg2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_addr_q[$];
  logic [7:0] got_beat_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_addr_q[$];
  int         done_cnt;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- RAM models ----------------
  logic [7:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 8'(i);

  always @(posedge clk) begin
    if (ram_rd_en1) ram_rd_data1 <= mem[ram_rd_addr1];
    if (ram_rd_en2) ram_d1_2 <= mem[ram_rd_addr2];
    ram_rd_data2 <= ram_d1_2;
  end

  bram_stream_reader #(.DATA_WIDTH(8), .DEPTH(8), .OUTPUT_REGISTER("false")) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr), .length(length),
    .busy(busy1), .done(done1), .ram_rd_addr(ram_rd_addr1), .ram_rd_en(ram_rd_en1),
    .ram_rd_data(ram_rd_data1), .o_data(o_data1), .o_valid(o_valid1),
    .o_ready(ready1), .o_dbg_state(dbg1)
  );

  bram_stream_reader #(.DATA_WIDTH(8), .DEPTH(8), .OUTPUT_REGISTER("true")) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr), .length(length),
    .busy(busy2), .done(done2), .ram_rd_addr(ram_rd_addr2), .ram_rd_en(ram_rd_en2),
    .ram_rd_data(ram_rd_data2), .o_data(o_data2), .o_valid(o_valid2),
    .o_ready(ready2), .o_dbg_state(dbg2)
  );

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk({tag, "_item"}, 32'(got[i]), 32'(exp[i]));
    end
  endtask

  // Pulses start1 with the given burst, then records reads, beats and done
  // pulses of u_dut1 for `budget` periods. A second start can be injected
  // at iteration restart_at (base 5, length 2).
  task automatic burst1(input logic [2:0] b, input logic [3:0] l,
                        input int budget, input int restart_at);
    base_addr = b;
    length    = l;
    start1    = 1'b1;
    step();
    start1 = 1'b0;
    got_addr_q.delete();
    got_beat_q.delete();
    done_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      if (ram_rd_en1) got_addr_q.push_back(8'(ram_rd_addr1));
      if (o_valid1 && ready1) got_beat_q.push_back(o_data1);
      if (done1) done_cnt++;
      start1 = (i == restart_at);
      if (i == restart_at) begin
        base_addr = 3'd5;
        length    = 4'd2;
      end
      step();
    end
    start1 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int exp_v [8];
    int exp_en[8];
    int exp_dn[8];
    int exp_bz[8];
    int outstanding;

    // Reset state (rst still high)
    rst = 1'b1;
    step();
    step();
    chk("rst_busy",   32'(busy1), 0);
    chk("rst_done",   32'(done1), 0);
    chk("rst_rd_en",  32'(ram_rd_en1), 0);
    chk("rst_addr",   32'(ram_rd_addr1), 0);
    chk("rst_valid",  32'(o_valid1), 0);
    chk("rst_data",   32'(o_data1), 0);
    chk("rst_state",  32'(dbg1), 0);
    chk("rst_valid2", 32'(o_valid2), 0);
    rst = 1'b0;

    // Burst base 2 length 4, o_ready high: beats 2..5 in periods 2..5, done in 6
    exp_v  = '{0, 0, 1, 1, 1, 1, 0, 0};
    exp_en = '{0, 1, 1, 1, 1, 0, 0, 0};
    exp_dn = '{0, 0, 0, 0, 0, 0, 1, 0};
    exp_bz = '{0, 1, 1, 1, 1, 1, 0, 0};
    ready1    = 1'b1;
    base_addr = 3'd2;
    length    = 4'd4;
    start1    = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 1; k < 8; k++) begin
      chk("a_valid", 32'(o_valid1), 32'(exp_v[k]));
      if (exp_v[k] == 1) chk("a_data", 32'(o_data1), 32'(k));
      chk("a_rd_en", 32'(ram_rd_en1), 32'(exp_en[k]));
      if (exp_en[k] == 1) chk("a_addr", 32'(ram_rd_addr1), 32'(k + 1));
      chk("a_done", 32'(done1), 32'(exp_dn[k]));
      chk("a_busy", 32'(busy1), 32'(exp_bz[k]));
      step();
    end
    chk("a_hold_addr", 32'(ram_rd_addr1), 5);

    // Wrapping burst base 6 length 4
    burst1(3'd6, 4'd4, 12, -1);
    exp_addr_q = '{8'd6, 8'd7, 8'd0, 8'd1};
    exp_q      = '{8'd6, 8'd7, 8'd0, 8'd1};
    chk_q("b_addr", got_addr_q, exp_addr_q);
    chk_q("b_beat", got_beat_q, exp_q);
    chk("b_done_cnt", 32'(done_cnt), 1);

    // Zero length: done next period, no read, busy stays low
    base_addr = 3'd3;
    length    = 4'd0;
    start1    = 1'b1;
    step();
    start1 = 1'b0;
    chk("z_done1",  32'(done1), 1);
    chk("z_busy1",  32'(busy1), 0);
    chk("z_rd_en1", 32'(ram_rd_en1), 0);
    chk("z_state1", 32'(dbg1), 0);
    step();
    chk("z_done2",  32'(done1), 0);
    chk("z_busy2",  32'(busy1), 0);
    chk("z_rd_en2", 32'(ram_rd_en1), 0);

    // Start again while busy is ignored
    burst1(3'd0, 4'd3, 14, 1);
    exp_addr_q = '{8'd0, 8'd1, 8'd2};
    exp_q      = '{8'd0, 8'd1, 8'd2};
    chk_q("c_addr", got_addr_q, exp_addr_q);
    chk_q("c_beat", got_beat_q, exp_q);
    chk("c_done_cnt", 32'(done_cnt), 1);
    chk("c_idle", 32'(dbg1), 0);

    // Reset mid-burst with o_ready low; the read issued in period 1 returns
    // while reset is held and must be dropped.
    ready1    = 1'b0;
    base_addr = 3'd0;
    length    = 4'd8;
    start1    = 1'b1;
    step();
    start1 = 1'b0;
    step();
    chk("r_busy_pre", 32'(busy1), 1);
    rst = 1'b1;
    step();
    chk("r_valid", 32'(o_valid1), 0);
    chk("r_data",  32'(o_data1), 0);
    chk("r_busy",  32'(busy1), 0);
    chk("r_done",  32'(done1), 0);
    chk("r_rd_en", 32'(ram_rd_en1), 0);
    chk("r_addr",  32'(ram_rd_addr1), 0);
    chk("r_state", 32'(dbg1), 0);
    rst    = 1'b0;
    ready1 = 1'b1;
    got_beat_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_valid1) got_beat_q.push_back(o_data1);
      if (done1 || ram_rd_en1) done_cnt++;
      step();
    end
    chk("r_late_beats", 32'(got_beat_q.size()), 0);
    chk("r_late_activity", 32'(done_cnt), 0);
    burst1(3'd3, 4'd2, 10, -1);
    exp_addr_q = '{8'd3, 8'd4};
    exp_q      = '{8'd3, 8'd4};
    chk_q("r2_addr", got_addr_q, exp_addr_q);
    chk_q("r2_beat", got_beat_q, exp_q);
    chk("r2_done_cnt", 32'(done_cnt), 1);

    // Two-cycle RAM, length 8 from base 5, random 50% o_ready
    base_addr = 3'd5;
    length    = 4'd8;
    start2    = 1'b1;
    step();
    start2 = 1'b0;
    got_beat_q.delete();
    done_cnt    = 0;
    outstanding = 0;
    for (int i = 0; i < 120; i++) begin
      ready2 = 1'($urandom_range(0, 1));
      if (ram_rd_en2) chk("f_credit", 32'(outstanding < 3), 1);
      if (o_valid2 && ready2) begin
        got_beat_q.push_back(o_data2);
        outstanding--;
      end
      if (ram_rd_en2) outstanding++;
      if (outstanding > 3) chk("f_occupancy", 32'(outstanding), 3);
      if (done2) done_cnt++;
      step();
    end
    ready2 = 1'b0;
    exp_q = '{8'd5, 8'd6, 8'd7, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    chk_q("f_beat", got_beat_q, exp_q);
    chk("f_done_cnt", 32'(done_cnt), 1);
    chk("f_busy_end", 32'(busy2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each RAM word and output beat.
REQ-002 Parameter DEPTH, default 2, number of RAM words; AW = $clog2(DEPTH).
REQ-003 Parameter OUTPUT_REGISTER, default "false", matches the RAM setting; RD_LAT = 2 if "true", else 1.
REQ-004 clk  input  1  sole clock; all logic is on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 base_addr  input  AW  first RAM address of the burst; sampled with start.
REQ-008 length  input  AW+1  number of words in the burst, 0..DEPTH; sampled with start.
REQ-009 busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
REQ-010 done  output  1  one-cycle pulse when the last beat is accepted downstream.
REQ-011 ram_rd_addr  output  AW  read address to the single-port RAM.
REQ-012 ram_rd_en  output  1  read enable to the RAM.
REQ-013 ram_rd_data  input  DATA_WIDTH  RAM read data, valid exactly RD_LAT cycles after ram_rd_en.
REQ-014 o_data  output  DATA_WIDTH  stream beat.
REQ-015 o_valid  output  1  o_data is valid.
REQ-016 o_ready  input  1  downstream accepts the beat when o_valid && o_ready.

Function
REQ-017 The FSM shall have states IDLE, ISSUE, DRAIN; IDLE->ISSUE on start with length>0; ISSUE->DRAIN after the final read is issued; DRAIN->IDLE when the last beat is accepted.
REQ-018 start with length==0 shall leave the FSM in IDLE and pulse done on the next cycle, with no RAM read issued.
REQ-019 start while busy shall be ignored.
REQ-020 In ISSUE, ram_rd_en shall be asserted only when in_flight + fifo_count < RD_LAT+1, guaranteeing every returned word has a FIFO slot.
REQ-021 The issue address shall start at base_addr and increment by 1 per issued read, wrapping from DEPTH-1 to 0.
REQ-022 ram_rd_addr shall hold its last value when ram_rd_en is low.
REQ-023 A valid-shift pipeline of depth RD_LAT shall tag issued reads; ram_rd_data shall be written into the FIFO exactly in the cycle the tag emerges, never otherwise.
REQ-024 The FIFO shall hold RD_LAT+1 entries; o_valid = FIFO not empty; o_data = FIFO head (first-word-fall-through).
REQ-025 Simultaneous FIFO write and pop shall keep the count unchanged; the FIFO shall never overflow or underflow.
REQ-026 Beats shall leave in address order, exactly length beats per burst, none dropped or duplicated under any o_ready pattern.
REQ-027 With o_ready held high, throughput shall be one beat per cycle after an initial latency of RD_LAT+1 cycles from start.
REQ-028 done shall assert in the cycle after the handshake of the last beat; busy shall deassert in that same cycle.

Reset
REQ-029 While rst is high: FSM=IDLE, busy=0, done=0, ram_rd_en=0, ram_rd_addr=0, o_valid=0, o_data=0, FIFO and tag pipeline cleared.
REQ-030 rst mid-burst shall abort the burst; in-flight RAM data returning after reset shall be discarded, and no done pulse shall be issued for the aborted burst.

Structure
REQ-031 The RD_LAT derivation from OUTPUT_REGISTER shall live in a shared package/header also used by the RAM instantiation sites.
REQ-032 The FIFO shall be one sub-module, stream_fwft_fifo (parameters DATA_WIDTH, DEPTH), with its own synchronous active-high reset.
REQ-033 The block shall instantiate no RAM; it connects to an external single-port RAM through the ram_* ports.

Verification
REQ-034 DEPTH=8, OUTPUT_REGISTER="false", RAM[i]=i, start base_addr=2 length=4, o_ready=1 -> o_data 2,3,4,5 on consecutive cycles, first beat at cycle start+2, then one done pulse.
REQ-035 DEPTH=8, base_addr=6, length=4 -> ram_rd_addr sequence 6,7,0,1; beats RAM[6],RAM[7],RAM[0],RAM[1].
REQ-036 OUTPUT_REGISTER="true", length=8, o_ready random 50% -> all 8 beats in order, FIFO count never >3, ram_rd_en low whenever in_flight+count==3.
REQ-037 length=0 -> no ram_rd_en, done pulse at cycle start+1, busy stays 0.
REQ-038 rst for one cycle midway through an 8-beat burst with o_ready=0 -> o_valid=0 the next cycle, no late beats, no done; a new burst of length 2 then completes correctly.
REQ-039 start pulsed again while busy -> ignored; only the original burst's beats and done are observed.
